// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, reset PC, FSM encodings and the load-use compare for the hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int WORD_W    = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [WORD_W-1:0] PC_RST = 32'h1C00_0000;

  localparam logic [1:0] IC_FETCH      = 2'd0;
  localparam logic [1:0] IC_MISS       = 2'd1;
  localparam logic [1:0] IC_MISS_REDIR = 2'd2;
  localparam logic [1:0] IC_REDIR      = 2'd3;

  localparam logic [0:0] DIV_IDLE = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

  typedef struct packed {
    logic pc_stall;
    logic pc_redirect;
    logic if1_id_stall;
    logic if1_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_stall;
  } ctrl_t;

  function automatic logic load_use(
    input logic       is_load,
    input logic [4:0] rd,
    input logic [4:0] rj,
    input logic       rj_used,
    input logic [4:0] rk,
    input logic       rk_used
  );
    return is_load && (rd != 5'd0) && ((rj_used && (rj == rd)) || (rk_used && (rk == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_div.sv
// Divider occupancy counter: div_busy for DIV_LAT-1 cycles after a start accepted in IDLE.
// Latency: div_busy rises the cycle after start; registered state, no combinational path from start.
// Backpressure: none; starts seen while BUSY are dropped, dcache freezes do not pause the count.
module div_occupancy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic div_busy
);

  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LAT - 1);

  logic [0:0]           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else if (state_q == DIV_IDLE) begin
      if (start) begin
        state_q <= DIV_BUSY;
        cnt_q   <= CNT_LOAD;
      end
    end else if (cnt_q == '0) begin
      state_q <= DIV_IDLE;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // The cnt==0 cycle is the result cycle, so it is deliberately not stalled.
  assign div_busy = (state_q == DIV_BUSY) && (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect controller for the five-stage pipeline, incl. deferred redirect over ICache refill.
// Latency: all controls are Mealy outputs of the current inputs and state; deferred redirect fires 1 cycle after icache_ready.
// Backpressure: dcache_stall freezes every stage; REDIR is held until the redirect can actually be issued.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcache_stall,
  input  logic              icache_miss,
  input  logic              icache_ready,
  input  logic              ex_branch_taken,
  input  logic [WORD_W-1:0] ex_branch_target,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        id_rj,
  input  logic [4:0]        id_rk,
  input  logic              id_rj_used,
  input  logic              id_rk_used,
  input  logic              ex_div_start,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [WORD_W-1:0] pc_redirect_target,
  output logic              if1_id_stall,
  output logic              if1_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              ex_mem_flush,
  output logic              mem_wb_stall,
  output logic              div_busy
);

  logic [1:0]        ic_state_q, ic_state_d;
  logic [WORD_W-1:0] redir_q, redir_d;
  logic              lu;
  logic              ic_wait;
  logic              redir_go;
  ctrl_t             ctrl;

  div_occupancy_cnt #(.DIV_LAT(DIV_LAT)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (ex_div_start),
    .div_busy (div_busy)
  );

  assign lu = load_use(ex_is_load, ex_rd, id_rj, id_rj_used, id_rk, id_rk_used);

  assign ic_wait = (ic_state_q == IC_MISS) || (ic_state_q == IC_MISS_REDIR) ||
                   ((ic_state_q == IC_FETCH) && icache_miss);

  // REDIR only retires once the redirect really reaches the PC; a fresh branch supersedes redir_q.
  assign redir_go = (ic_state_q == IC_REDIR) && !dcache_stall &&
                    (ex_branch_taken || (!div_busy && !lu));

  always_comb begin
    ic_state_d = ic_state_q;
    redir_d    = redir_q;
    case (ic_state_q)
      IC_FETCH: begin
        if (icache_miss) begin
          if (ex_branch_taken) begin
            ic_state_d = IC_MISS_REDIR;
            redir_d    = ex_branch_target;
          end else begin
            ic_state_d = IC_MISS;
          end
        end
      end
      IC_MISS: begin
        if (ex_branch_taken) begin
          redir_d    = ex_branch_target;
          ic_state_d = icache_ready ? IC_REDIR : IC_MISS_REDIR;
        end else if (icache_ready) begin
          ic_state_d = IC_FETCH;
        end
      end
      IC_MISS_REDIR: begin
        if (ex_branch_taken) redir_d = ex_branch_target;
        if (icache_ready)    ic_state_d = IC_REDIR;
      end
      default: begin
        if (redir_go) ic_state_d = IC_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_state_q <= IC_FETCH;
      redir_q    <= PC_RST;
    end else begin
      ic_state_q <= ic_state_d;
      redir_q    <= redir_d;
    end
  end

  always_comb begin
    ctrl               = '0;
    pc_redirect_target = ex_branch_taken ? ex_branch_target : redir_q;
    if (rst) begin
      pc_redirect_target = PC_RST;
    end else if (dcache_stall) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if1_id_stall = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_stall = 1'b1;
    end else if (ex_branch_taken) begin
      // While a refill is outstanding the redirect is parked in redir_q and the PC holds.
      ctrl.pc_redirect  = (ic_state_q == IC_REDIR) || ((ic_state_q == IC_FETCH) && !icache_miss);
      ctrl.pc_stall     = !ctrl.pc_redirect;
      ctrl.if1_id_flush = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end else if (div_busy) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if1_id_stall = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
    end else if (lu) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if1_id_stall = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end else if (ic_state_q == IC_REDIR) begin
      ctrl.pc_redirect  = 1'b1;
      ctrl.if1_id_flush = 1'b1;
    end else if (ic_wait) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if1_id_flush = 1'b1;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign pc_redirect  = ctrl.pc_redirect;
  assign if1_id_stall = ctrl.if1_id_stall;
  assign if1_id_flush = ctrl.if1_id_flush;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_stall = ctrl.mem_wb_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DIV_LAT=4; expected control vectors are hand-computed.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] PS = 9'h100;  // pc_stall
  localparam logic [8:0] PR = 9'h080;  // pc_redirect
  localparam logic [8:0] FS = 9'h040;  // if1_id_stall
  localparam logic [8:0] FF = 9'h020;  // if1_id_flush
  localparam logic [8:0] DS = 9'h010;  // id_ex_stall
  localparam logic [8:0] DF = 9'h008;  // id_ex_flush
  localparam logic [8:0] ES = 9'h004;  // ex_mem_stall
  localparam logic [8:0] EF = 9'h002;  // ex_mem_flush
  localparam logic [8:0] WS = 9'h001;  // mem_wb_stall
  localparam logic [8:0] ALLS = PS | FS | DS | ES | WS;
  localparam logic [31:0] PC_RST_EXP = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dcache_stall, icache_miss, icache_ready, ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        ex_is_load;
  logic [4:0]  ex_rd, id_rj, id_rk;
  logic        id_rj_used, id_rk_used, ex_div_start;
  logic        pc_stall, pc_redirect, if1_id_stall, if1_id_flush;
  logic        id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, div_busy;
  logic [31:0] pc_redirect_target;
  logic [8:0]  outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_LAT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .dcache_stall       (dcache_stall),
    .icache_miss        (icache_miss),
    .icache_ready       (icache_ready),
    .ex_branch_taken    (ex_branch_taken),
    .ex_branch_target   (ex_branch_target),
    .ex_is_load         (ex_is_load),
    .ex_rd              (ex_rd),
    .id_rj              (id_rj),
    .id_rk              (id_rk),
    .id_rj_used         (id_rj_used),
    .id_rk_used         (id_rk_used),
    .ex_div_start       (ex_div_start),
    .pc_stall           (pc_stall),
    .pc_redirect        (pc_redirect),
    .pc_redirect_target (pc_redirect_target),
    .if1_id_stall       (if1_id_stall),
    .if1_id_flush       (if1_id_flush),
    .id_ex_stall        (id_ex_stall),
    .id_ex_flush        (id_ex_flush),
    .ex_mem_stall       (ex_mem_stall),
    .ex_mem_flush       (ex_mem_flush),
    .mem_wb_stall       (mem_wb_stall),
    .div_busy           (div_busy)
  );

  assign outs = {pc_stall, pc_redirect, if1_id_stall, if1_id_flush, id_ex_stall,
                 id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall};

  task automatic clr();
    dcache_stall     = 1'b0;
    icache_miss      = 1'b0;
    icache_ready     = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'h0;
    ex_is_load       = 1'b0;
    ex_rd            = 5'd0;
    id_rj            = 5'd0;
    id_rk            = 5'd0;
    id_rj_used       = 1'b0;
    id_rk_used       = 1'b0;
    ex_div_start     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    #2;
    icache_miss      = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0000_1234;
    #1;
    total++;
    if (outs !== 9'h0) begin bad++; $display("FAIL reset_outs: got %h want %h", outs, 9'h0); end
    total++;
    if (pc_redirect_target !== PC_RST_EXP) begin
      bad++; $display("FAIL reset_target: got %h want %h", pc_redirect_target, PC_RST_EXP);
    end
    clr();
    @(negedge clk);
    rst = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (outs !== 9'h0) begin bad++; $display("FAIL post_reset_outs: got %h want %h", outs, 9'h0); end
    total++;
    if (pc_redirect_target !== PC_RST_EXP) begin
      bad++; $display("FAIL post_reset_target: got %h want %h", pc_redirect_target, PC_RST_EXP);
    end
  endtask

  task automatic test_load_use();
    logic [8:0] exp [6];
    exp = '{PS | FS | DF, 9'h0, 9'h0, PS | FS | DF, 9'h0, 9'h0};
    for (int c = 0; c < 6; c++) begin
      step(); clr();
      case (c)
        0: begin ex_is_load = 1; ex_rd = 5'd5; id_rj = 5'd5; id_rj_used = 1; end
        2: begin ex_is_load = 1; ex_rd = 5'd0; id_rj = 5'd0; id_rj_used = 1; end
        3: begin ex_is_load = 1; ex_rd = 5'd7; id_rk = 5'd7; id_rk_used = 1; end
        4: begin ex_is_load = 1; ex_rd = 5'd7; id_rk = 5'd7; id_rj = 5'd3; id_rj_used = 1; end
        5: begin ex_is_load = 0; ex_rd = 5'd9; id_rj = 5'd9; id_rj_used = 1; end
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (outs !== exp[c]) begin bad++; $display("FAIL load_use c%0d: got %h want %h", c, outs, exp[c]); end
    end
  endtask

  task automatic test_branch_beats_lu();
    step(); clr();
    ex_is_load = 1; ex_rd = 5'd5; id_rj = 5'd5; id_rj_used = 1;
    ex_branch_taken = 1; ex_branch_target = 32'h1C00_0100;
    @(negedge clk);
    total++;
    if (outs !== (PR | FF | DF)) begin bad++; $display("FAIL branch_lu: got %h want %h", outs, PR | FF | DF); end
    total++;
    if (pc_redirect_target !== 32'h1C00_0100) begin
      bad++; $display("FAIL branch_lu_target: got %h want %h", pc_redirect_target, 32'h1C00_0100);
    end
  endtask

  task automatic test_deferred_redirect();
    logic [8:0] exp [9];
    exp = '{PS | FF, PS | FF | DF, PS | FF, PS | FF, PS | FF, PS | FF, PS | FF, PR | FF, 9'h0};
    for (int c = 0; c < 9; c++) begin
      step(); clr();
      ex_branch_target = 32'hDEAD_BEEF;
      if (c == 0) icache_miss = 1;
      if (c == 1) begin ex_branch_taken = 1; ex_branch_target = 32'h1C00_0200; end
      if (c == 6) icache_ready = 1;
      @(negedge clk);
      total++;
      if (outs !== exp[c]) begin bad++; $display("FAIL deferred c%0d: got %h want %h", c, outs, exp[c]); end
      if (c == 7) begin
        total++;
        if (pc_redirect_target !== 32'h1C00_0200) begin
          bad++; $display("FAIL deferred_target: got %h want %h", pc_redirect_target, 32'h1C00_0200);
        end
      end
    end
  endtask

  task automatic test_miss_ready_same_cycle();
    logic [8:0] exp [6];
    exp = '{PS | FF, PS | FF, PS | FF, PS | FF, PS | FF, 9'h0};
    for (int c = 0; c < 6; c++) begin
      step(); clr();
      if (c <= 2) icache_miss = 1;
      if (c == 1 || c == 4) icache_ready = 1;
      @(negedge clk);
      total++;
      if (outs !== exp[c]) begin bad++; $display("FAIL miss_ready c%0d: got %h want %h", c, outs, exp[c]); end
    end
  endtask

  task automatic test_divide();
    logic [8:0] exp [7];
    exp = '{9'h0, PS | FS | DS | EF, PS | FS | DS | EF, PS | FS | DS | EF, 9'h0, 9'h0, 9'h0};
    for (int c = 0; c < 7; c++) begin
      step(); clr();
      if (c == 0 || c == 2) ex_div_start = 1;
      @(negedge clk);
      total++;
      if (outs !== exp[c]) begin bad++; $display("FAIL divide c%0d: got %h want %h", c, outs, exp[c]); end
      total++;
      if (div_busy !== (c >= 1 && c <= 3)) begin
        bad++; $display("FAIL div_busy c%0d: got %b want %b", c, div_busy, (c >= 1 && c <= 3));
      end
    end
  endtask

  task automatic test_dcache_freeze();
    logic [8:0] exp [10];
    exp = '{ALLS, PR | FF | DF, 9'h0, PS | FF, PS | FF | DF, PS | FF, ALLS, ALLS, PR | FF, 9'h0};
    for (int c = 0; c < 10; c++) begin
      step(); clr();
      ex_branch_target = 32'hDEAD_BEEF;
      case (c)
        0: begin dcache_stall = 1; ex_branch_taken = 1; ex_branch_target = 32'h1C00_0400; end
        1: begin ex_branch_taken = 1; ex_branch_target = 32'h1C00_0400; end
        3: icache_miss = 1;
        4: begin ex_branch_taken = 1; ex_branch_target = 32'h1C00_0300; end
        5: icache_ready = 1;
        6, 7: dcache_stall = 1;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (outs !== exp[c]) begin bad++; $display("FAIL dcache c%0d: got %h want %h", c, outs, exp[c]); end
      if (c == 1 || c == 8) begin
        total++;
        if (pc_redirect_target !== ((c == 1) ? 32'h1C00_0400 : 32'h1C00_0300)) begin
          bad++; $display("FAIL dcache_target c%0d: got %h", c, pc_redirect_target);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(); clr(); icache_miss = 1;
    step(); clr(); ex_branch_taken = 1; ex_branch_target = 32'h1C00_0500;
    step(); clr(); icache_miss = 1; ex_branch_target = 32'h1C00_0600;
    @(negedge clk);
    total++;
    if (outs !== (PS | FF)) begin bad++; $display("FAIL arst_pre: got %h want %h", outs, PS | FF); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs !== 9'h0) begin bad++; $display("FAIL arst_outs: got %h want %h", outs, 9'h0); end
    total++;
    if (pc_redirect_target !== PC_RST_EXP) begin
      bad++; $display("FAIL arst_target: got %h want %h", pc_redirect_target, PC_RST_EXP);
    end
    clr();
    #1 rst = 1'b0;
    step(); clr(); icache_ready = 1;
    @(negedge clk);
    total++;
    if (outs !== 9'h0) begin bad++; $display("FAIL arst_fetch: got %h want %h", outs, 9'h0); end
    step(); clr();
    @(negedge clk);
    total++;
    if (outs !== 9'h0) begin bad++; $display("FAIL arst_no_redir: got %h want %h", outs, 9'h0); end
    total++;
    if (pc_redirect_target !== PC_RST_EXP) begin
      bad++; $display("FAIL arst_redir_q: got %h want %h", pc_redirect_target, PC_RST_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_beats_lu();
    test_deferred_redirect();
    test_miss_ready_same_cycle();
    test_divide();
    test_dcache_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
